// File: rtl/regfile_scan_pkg.sv
// Shared definitions for the register-file scanner: state encoding and datapath widths.
package regfile_scan_pkg;

  localparam int IDX_W  = 5;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } scanState_t;

endpackage

// File: rtl/regfile_scan.sv
// Walks register indices FIRST_REG..LAST_REG through an external read port and
// streams each (index, data) pair out over a valid/ready handshake.
module regfile_scan
  import regfile_scan_pkg::*;
#(
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31  // must satisfy FIRST_REG <= LAST_REG <= 31
) (
  input  logic              clock,
  input  logic              ctrl_reset,
  input  logic              start,
  input  logic              abort,
  output logic [IDX_W-1:0]  ctrl_readReg,
  input  logic [DATA_W-1:0] data_readReg,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  out_index,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done
);

  localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(FIRST_REG);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(LAST_REG);

  scanState_t       state;
  logic [IDX_W-1:0] idx;

  // The read address follows idx in every state; only READ relies on it.
  assign ctrl_readReg = idx;

  // All handshake/status outputs are registered alongside the state so they
  // change only on clock edges (or asynchronously on reset).
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      state     <= IDLE;
      idx       <= FIRST_IDX;
      out_data  <= '0;
      out_index <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            idx   <= FIRST_IDX;
            state <= READ;
            busy  <= 1'b1;
          end
        end

        READ: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            out_data  <= data_readReg;
            out_index <= idx;
            out_valid <= 1'b1;
            state     <= SEND;
          end
        end

        SEND: begin
          // Abort wins over a transfer presented on the same edge.
          if (abort) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            if (idx == LAST_IDX) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              idx   <= idx + 5'd1;
              state <= READ;
            end
          end
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end

        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule
